// File: rtl/exe_ctrl_pipe_if.sv
// rtl/exe_ctrl_pipe_if.sv - decode-to-DSP48E1 control pipe bundle with master/slave views
interface exe_ctrl_pipe_if #(
    parameter int CTRL_W = 5,
    parameter int STAGES = 2
);
    localparam int OCC_W = $clog2(STAGES + 1);

    logic              VALID_IN;
    logic [CTRL_W-1:0] CTRL_IN;
    logic              CEP_IN;
    logic              STALL;
    logic              FLUSH;
    logic [CTRL_W-1:0] CTRL_OUT;
    logic              CEP_OUT;
    logic              VALID_OUT;
    logic [STAGES-1:0] CE_STAGE;
    logic              BUSY;
    logic [OCC_W-1:0]  OCC;
    logic [15:0]       OP_CNT;

    modport master (
        output VALID_IN, CTRL_IN, CEP_IN, STALL, FLUSH,
        input  CTRL_OUT, CEP_OUT, VALID_OUT, CE_STAGE, BUSY, OCC, OP_CNT
    );

    modport slave (
        input  VALID_IN, CTRL_IN, CEP_IN, STALL, FLUSH,
        output CTRL_OUT, CEP_OUT, VALID_OUT, CE_STAGE, BUSY, OCC, OP_CNT
    );
endinterface

// File: rtl/exe_ctrl_pipe.sv
// rtl/exe_ctrl_pipe.sv - stallable/flushable execute-stage control delay line; EXE_OPCNT_EN adds retired-op counter
module exe_ctrl_pipe #(
    parameter int  CTRL_W = 5,
    parameter int  STAGES = 2,
    localparam int OCC_W  = $clog2(STAGES + 1)
) (
    input  logic            CLK,
    input  logic            RST,
    exe_ctrl_pipe_if.slave  bus
);

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] cep;
    logic [STAGES-1:0] feed;
    logic [CTRL_W-1:0] ctrl [STAGES];
    logic [OCC_W-1:0]  occ;
    logic              adv;

    assign adv = ~bus.STALL & ~bus.FLUSH;

    // feed[i] is the valid bit that stage i would capture on an advancing edge
    always_comb begin
        feed    = '0;
        feed[0] = bus.VALID_IN;
        for (int i = 1; i < STAGES; i++) begin
            feed[i] = v[i-1];
        end
    end

    assign bus.CE_STAGE = feed & {STAGES{adv}};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            v   <= '0;
            cep <= '0;
            occ <= '0;
            for (int i = 0; i < STAGES; i++) begin
                ctrl[i] <= '0;
            end
        end else if (bus.FLUSH) begin
            v   <= '0;
            cep <= '0;
            occ <= '0;
            for (int i = 0; i < STAGES; i++) begin
                ctrl[i] <= '0;
            end
        end else if (!bus.STALL) begin
            v       <= feed;
            // bubbles carry all-zero control so the DSP never sees stale INMODE
            ctrl[0] <= bus.VALID_IN ? bus.CTRL_IN : '0;
            cep[0]  <= bus.VALID_IN & bus.CEP_IN;
            for (int i = 1; i < STAGES; i++) begin
                ctrl[i] <= ctrl[i-1];
                cep[i]  <= cep[i-1];
            end
            occ <= occ + OCC_W'(bus.VALID_IN) - OCC_W'(v[STAGES-1]);
        end
    end

    assign bus.CTRL_OUT  = ctrl[STAGES-1];
    assign bus.CEP_OUT   = cep[STAGES-1] & v[STAGES-1];
    assign bus.VALID_OUT = v[STAGES-1];
    assign bus.BUSY      = |v;
    assign bus.OCC       = occ;

`ifdef EXE_OPCNT_EN
    logic [15:0] op_cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            op_cnt <= 16'h0000;
        end else if (adv && v[STAGES-1]) begin
            op_cnt <= op_cnt + 16'd1;
        end
    end

    assign bus.OP_CNT = op_cnt;
`else
    assign bus.OP_CNT = 16'h0000;
`endif

endmodule

// File: doc/exe_ctrl_pipe.md
# exe_ctrl_pipe

Parametrised execute-stage control pipeline for the streaming IPPro datapath. It replaces the single fixed EXE1 pass-through with a configurable-depth, stallable, flushable delay line. The line carries the DSP48E1 control word (INMODE and related fields) and CEP alongside a valid bit. It also generates per-stage clock enables for the DSP48E1 internal pipeline registers. It sits between decode and the DSP48E1 instance.

## Interface
Parameters:
- CTRL_W, 5, control-word width (5 = INMODE only); legal range 1..32
- STAGES, 2, pipeline depth in cycles; legal range 1..8
- OCC_W, $clog2(STAGES+1), occupancy counter width (derived, not overridden)

Ports:
- CLK  input  1  single clock, all state updates on rising edge
- RST  input  1  asynchronous, active-high reset
- VALID_IN  input  1  CTRL_IN/CEP_IN carry a valid op this cycle
- CTRL_IN  input  CTRL_W  control word for the op
- CEP_IN  input  1  P-register enable request for the op
- STALL  input  1  hold all stages
- FLUSH  input  1  invalidate all stages
- CTRL_OUT  output  CTRL_W  control word of the last stage
- CEP_OUT  output  1  CEP of the last stage, gated by valid
- VALID_OUT  output  1  last stage holds a valid op
- CE_STAGE  output  STAGES  per-stage DSP48E1 register enables
- BUSY  output  1  any stage valid
- OCC  output  OCC_W  number of valid stages
- OP_CNT  output  16  retired-op counter (see Configuration)

## Operation
- State: stages 0..STAGES-1, each holding v[i], ctrl[i] and cep[i]. Stage 0 is the input end.
- Advance (STALL=0, FLUSH=0):
  - v[0]<=VALID_IN.
  - ctrl[0]<=VALID_IN?CTRL_IN:0 and cep[0]<=VALID_IN&CEP_IN, so bubbles carry all-zero control.
  - Stage i takes stage i-1.
- Stall (STALL=1, FLUSH=0): all stages hold. The input op is ignored, and the upstream block must hold it.
- Flush (FLUSH=1): all v, ctrl and cep clear to 0 on the next edge. FLUSH has priority over STALL. A VALID_IN presented in the same cycle is dropped.
- Outputs:
  - CTRL_OUT=ctrl[STAGES-1]
  - CEP_OUT=cep[STAGES-1]&v[STAGES-1]
  - VALID_OUT=v[STAGES-1]
  - BUSY=|v
- CE_STAGE[i] is combinational: ~STALL & ~FLUSH & (i==0 ? VALID_IN : v[i-1]). It asserts exactly when stage i captures a valid op.
- OCC is a registered counter:
  - On flush: 0.
  - On stall: hold.
  - On advance: OCC + VALID_IN − v[STAGES-1].
  - OCC always equals the population count of v; the bench checks this invariant every cycle.
- Reset: all v/ctrl/cep = 0, OCC=0, OP_CNT=0. Hence CTRL_OUT=0, CEP_OUT=0, VALID_OUT=0, BUSY=0, and CE_STAGE=VALID_IN-dependent only (0 for stages ≥1).

## Timing
- Latency: an op accepted at edge n appears on the outputs after edge n+STAGES−1 (STAGES cycles input-to-output), plus one cycle per stalled cycle in between.
- Throughput: one op per cycle with STALL=0. No bubbles are inserted.
- STALL with an empty pipe is legal. It holds zeros, and CE_STAGE is all 0.
- Reset asserted mid-operation: all in-flight ops are discarded immediately (asynchronously). The first op after deassertion sees the normal latency.
- STAGES=1 degenerates to a single register stage: CE_STAGE[0]=~STALL&~FLUSH&VALID_IN.

## Configuration
- Macro EXE_OPCNT_EN.
- Defined: OP_CNT is a 16-bit counter. It increments on every edge where VALID_OUT=1 & STALL=0 & FLUSH=0 (op retired), wraps 0xFFFF→0x0000, and resets to 0.
- Undefined: no counter logic is built, and OP_CNT is tied to 16'h0000.

## Test plan
- STAGES=2: reset, then VALID_IN=1, CTRL_IN=5'h11, CEP_IN=1 for one cycle → VALID_OUT=1, CTRL_OUT=5'h11, CEP_OUT=1 exactly 2 cycles later, one cycle wide. OCC goes 0→1→1→0.
- Back-to-back ops 5'h01..5'h08 with STALL=0 → the outputs stream 5'h01..5'h08 on consecutive cycles. OCC holds at 2 mid-stream.
- Stream 5'h0A,5'h0B with STALL=1 for 3 cycles after the first edge → the outputs are delayed by exactly 3 cycles, and CE_STAGE=0 during the stall. No op is lost or duplicated.
- Pipe full (OCC=2), then FLUSH=1 together with STALL=1 and VALID_IN=1 → next cycle VALID_OUT=0, CTRL_OUT=0, OCC=0, BUSY=0, and the input op never emerges.
- RST pulsed asynchronously between edges with OCC=2 → all outputs 0 immediately. After release, a new op emerges with 2-cycle latency.
- With EXE_OPCNT_EN defined, preload by issuing 65 537 ops → OP_CNT=1 (wrap). Without the macro, OP_CNT=0 throughout.
